// File: rtl/fp_float2int.sv
// IEEE-754 single to WIDE-bit integer, round-to-nearest-even, scaled by 2^src1.
// Three-stage valid/ready pipeline; all stages stall together on backpressure.
module fp_float2int #(
    parameter int WIDE = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     src0,
    input  logic [5:0]      src1,
    input  logic            is_signed,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [WIDE-1:0] out,
    output logic            ovf,
    output logic            inexact
);

    localparam int XW = WIDE + 26;
    localparam logic [WIDE-1:0] MAXS = {1'b0, {(WIDE-1){1'b1}}};
    localparam logic [WIDE-1:0] MINS = {1'b1, {(WIDE-1){1'b0}}};
    localparam logic [WIDE-1:0] ONES = '1;
    localparam logic [WIDE-1:0] ONE  = {{(WIDE-1){1'b0}}, 1'b1};
    localparam logic [WIDE+1:0] LIM_S = {2'b00, MAXS};
    localparam logic [WIDE+1:0] LIM_U = {2'b00, ONES};
    localparam logic [WIDE+1:0] LIM_N = {2'b00, MINS};
    localparam logic signed [9:0] EMAX = 10'(WIDE);
    localparam logic signed [9:0] EMIN = -10'sd1;

    logic w_adv;

    logic [7:0]  w_exp;
    logic        w_fnz;
    logic [9:0]  w_e;

    logic        r_s1_v;
    logic        r_s1_sign;
    logic        r_s1_signed;
    logic        r_s1_zero;
    logic        r_s1_nan;
    logic        r_s1_inf;
    logic        r_s1_fnz;
    logic [23:0] r_s1_sig;
    logic [9:0]  r_s1_e;

    logic [9:0]    w_sh;
    logic [XW-1:0] w_x;
    logic          w_huge;
    logic          w_tiny;
    logic [WIDE:0] w_mag;
    logic          w_g;
    logic          w_r;
    logic          w_s;
    logic          w_big;

    logic          r_s2_v;
    logic          r_s2_sign;
    logic          r_s2_signed;
    logic          r_s2_nan;
    logic          r_s2_big;
    logic [WIDE:0] r_s2_mag;
    logic          r_s2_g;
    logic          r_s2_r;
    logic          r_s2_s;

    logic            w_up;
    logic            w_inx_raw;
    logic [WIDE+1:0] w_rmag;
    logic [WIDE-1:0] w_out;
    logic            w_ovf;
    logic            w_inx;

    logic            r_s3_v;
    logic [WIDE-1:0] r_out;
    logic            r_ovf;
    logic            r_inx;

    assign w_adv     = out_ready || !r_s3_v;
    assign in_ready  = w_adv;
    assign out_valid = r_s3_v;
    assign out       = r_out;
    assign ovf       = r_ovf;
    assign inexact   = r_inx;

    assign w_exp = src0[30:23];
    assign w_fnz = |src0[22:0];
    assign w_e   = {2'b00, w_exp} - 10'd127 + {{4{src1[5]}}, src1};

    // Integer bit k lands at index 25+k; bits 24/23 are guard/round, below is sticky
    assign w_sh   = r_s1_e + 10'd2;
    assign w_x    = {{(WIDE+2){1'b0}}, r_s1_sig} << w_sh;
    assign w_huge = $signed(r_s1_e) > EMAX;
    assign w_tiny = $signed(r_s1_e) < EMIN;

    always_comb begin
        w_mag = '0;
        w_g   = 1'b0;
        w_r   = 1'b0;
        w_s   = 1'b0;
        w_big = 1'b0;
        if (r_s1_zero) begin
            w_s = r_s1_fnz;
        end else if (r_s1_nan || r_s1_inf || w_huge) begin
            w_big = !r_s1_nan;
        end else if (w_tiny) begin
            w_s = 1'b1;
        end else begin
            w_mag = w_x[XW-1:25];
            w_g   = w_x[24];
            w_r   = w_x[23];
            w_s   = |w_x[22:0];
        end
    end

    assign w_up      = r_s2_g & (r_s2_r | r_s2_s | r_s2_mag[0]);
    assign w_inx_raw = r_s2_g | r_s2_r | r_s2_s;
    assign w_rmag    = {1'b0, r_s2_mag} + {{(WIDE+1){1'b0}}, w_up};

    always_comb begin
        w_out = '0;
        w_ovf = 1'b0;
        w_inx = 1'b0;
        if (r_s2_nan) begin
            w_out = r_s2_signed ? MAXS : ONES;
            w_ovf = 1'b1;
        end else if (r_s2_big) begin
            w_ovf = 1'b1;
            if (r_s2_sign) w_out = r_s2_signed ? MINS : '0;
            else           w_out = r_s2_signed ? MAXS : ONES;
        end else if (!r_s2_sign) begin
            if (w_rmag > (r_s2_signed ? LIM_S : LIM_U)) begin
                w_out = r_s2_signed ? MAXS : ONES;
                w_ovf = 1'b1;
            end else begin
                w_out = w_rmag[WIDE-1:0];
                w_inx = w_inx_raw;
            end
        end else if (r_s2_signed) begin
            if (w_rmag > LIM_N) begin
                w_out = MINS;
                w_ovf = 1'b1;
            end else begin
                w_out = ~w_rmag[WIDE-1:0] + ONE;
                w_inx = w_inx_raw;
            end
        end else if (w_rmag != '0) begin
            w_ovf = 1'b1;
        end else begin
            w_inx = w_inx_raw;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_v      <= 1'b0;
            r_s1_sign   <= 1'b0;
            r_s1_signed <= 1'b0;
            r_s1_zero   <= 1'b0;
            r_s1_nan    <= 1'b0;
            r_s1_inf    <= 1'b0;
            r_s1_fnz    <= 1'b0;
            r_s1_sig    <= '0;
            r_s1_e      <= '0;
            r_s2_v      <= 1'b0;
            r_s2_sign   <= 1'b0;
            r_s2_signed <= 1'b0;
            r_s2_nan    <= 1'b0;
            r_s2_big    <= 1'b0;
            r_s2_mag    <= '0;
            r_s2_g      <= 1'b0;
            r_s2_r      <= 1'b0;
            r_s2_s      <= 1'b0;
            r_s3_v      <= 1'b0;
            r_out       <= '0;
            r_ovf       <= 1'b0;
            r_inx       <= 1'b0;
        end else if (w_adv) begin
            r_s1_v      <= in_valid;
            r_s1_sign   <= src0[31];
            r_s1_signed <= is_signed;
            r_s1_zero   <= w_exp == 8'h00;
            r_s1_nan    <= (w_exp == 8'hFF) && w_fnz;
            r_s1_inf    <= (w_exp == 8'hFF) && !w_fnz;
            r_s1_fnz    <= w_fnz;
            r_s1_sig    <= {1'b1, src0[22:0]};
            r_s1_e      <= w_e;
            r_s2_v      <= r_s1_v;
            r_s2_sign   <= r_s1_sign;
            r_s2_signed <= r_s1_signed;
            r_s2_nan    <= r_s1_nan;
            r_s2_big    <= w_big;
            r_s2_mag    <= w_mag;
            r_s2_g      <= w_g;
            r_s2_r      <= w_r;
            r_s2_s      <= w_s;
            r_s3_v      <= r_s2_v;
            r_out       <= w_out;
            r_ovf       <= w_ovf;
            r_inx       <= w_inx;
        end
    end

endmodule
